// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Main control sequencer for a multicycle MIPS datapath. It walks each
// instruction through fetch, decode and an opcode-specific execute path. Every
// cycle it drives the memory address select (IorD), the memory read/write
// requests and the datapath enables and mux selects.
//
// Memory cycles (FETCH, MEMRD, MEMWR) wait on the mem_ready handshake. Each
// completed instruction increments a wrapping retire counter. An opcode that
// the decoder does not recognise raises a one-cycle 'illegal' pulse, and the
// FSM then returns to FETCH without counting that instruction.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   opcode       IR[31:26], consulted in DECODE and MEMADR
//   mem_ready    memory handshake, qualifies every MemRead/MemWrite cycle
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      instruction register load
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU zero
//   RegDst       register destination: 1 = rd, 0 = rt
//   MemtoReg     register write data: 1 = MDR, 0 = ALUOut
//   RegWrite     register file write enable
//   ALUSrcA      ALU A operand: 0 = PC, 1 = A
//   ALUSrcB      ALU B operand: 00 B, 01 4, 10 signext, 11 signext<<2
//   ALUOp        ALU control: 00 add, 01 sub, 10 funct field
//   PCSource     PC source: 00 ALU, 01 ALUOut, 10 jump target
//   state        current state encoding (debug visibility)
//   illegal      one-cycle pulse after an unknown opcode is decoded
//   instr_count  retired-instruction count
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             retire;

    // Control values decoded from the state before the reset gate is applied
    logic       iord_c, mem_read_c, mem_write_c, ir_write_c, pc_write_c;
    logic       pc_write_cond_c, reg_dst_c, memto_reg_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic. 'retire' marks the final cycle of a completed
    // instruction, which is the cycle whose transition lands back in FETCH.
    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWR: begin
                state_d = mem_ready ? FETCH : MEMWR;
                retire  = mem_ready;
            end
            EXEC:   state_d = ALUWB;
            ALUWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            ADDIEX: state_d = ADDIWB;
            ADDIWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        instr_count_d = retire ? instr_count_q + CNT_ONE : instr_count_q;
    end

    // Moore-style control decode. FETCH is the one exception: it also uses
    // mem_ready, so that IR and PC load only on the cycle the fetch completes.
    always_comb begin
        iord_c          = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        reg_dst_c       = 1'b0;
        memto_reg_c     = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            DECODE: alu_src_b_c = 2'b11;
            MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
            end
            MEMWB: begin
                reg_write_c = 1'b1;
                memto_reg_c = 1'b1;
            end
            MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                pc_source_c     = 2'b01;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
            end
            ADDIEX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            ADDIWB: reg_write_c = 1'b1;
            default: ;
        endcase
    end

    // The state register already sits in FETCH during reset. The controls are
    // gated as well, because the FETCH decode would otherwise assert MemRead
    // while reset is held. The gate is combinational, so a reset asserted in
    // the middle of MEMWR removes MemWrite at once instead of at the next edge.
    always_comb begin
        IorD        = rst_n & iord_c;
        MemRead     = rst_n & mem_read_c;
        MemWrite    = rst_n & mem_write_c;
        IRWrite     = rst_n & ir_write_c;
        PCWrite     = rst_n & pc_write_c;
        PCWriteCond = rst_n & pc_write_cond_c;
        RegDst      = rst_n & reg_dst_c;
        MemtoReg    = rst_n & memto_reg_c;
        RegWrite    = rst_n & reg_write_c;
        ALUSrcA     = rst_n & alu_src_a_c;
        ALUSrcB     = rst_n ? alu_src_b_c : 2'b00;
        ALUOp       = rst_n ? alu_op_c    : 2'b00;
        PCSource    = rst_n ? pc_source_c : 2'b00;
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Scoreboard bench for mc_control_fsm. It uses a 4-bit retire counter so that
// wrap-around happens quickly.
//
// The driver issues one instruction at a time. For each instruction it expands
// the opcode into the list of states the instruction must visit. It then
// drives one cycle per entry and pushes that cycle's expected outputs into a
// queue. A separate monitor pops one entry on every falling edge and compares
// it with the DUT outputs. Directed reset checks are made with the monitor
// disabled.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic             RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All control outputs packed in a fixed order so one compare covers them
    logic [15:0] act_ctl;
    assign act_ctl = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                      RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    typedef struct packed {
        logic [15:0]      ctl;
        logic [3:0]       st;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic             mon_en = 1'b0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic             pend_ill = 1'b0;
    int               cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected control vector for one cycle in a given state. The values come
    // from the state output table; unlisted outputs stay 0.
    function automatic logic [15:0] exp_ctl(input int st, input logic rdy);
        logic iord = 0, mrd = 0, mwr = 0, irw = 0, pcw = 0, pcwc = 0;
        logic rdst = 0, m2r = 0, rw = 0, srca = 0;
        logic [1:0] srcb = 0, aop = 0, pcs = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {iord, mrd, mwr, irw, pcw, pcwc, rdst, m2r, rw, srca, srcb, aop, pcs};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h02 || op == 6'h04 ||
               op == 6'h08 || op == 6'h23 || op == 6'h2B;
    endfunction

    // Runs one instruction. It must be entered shortly after a rising edge
    // while the DUT is in FETCH, and it returns at the same phase of the
    // cycle after the instruction's last cycle. fstall and mstall are the
    // numbers of not-ready cycles inserted in FETCH and in the memory state.
    task automatic applyStimulus(input logic [5:0] op, input int fstall, input int mstall);
        int   sts[$];
        logic rdys[$];
        exp_t e;
        for (int i = 0; i < fstall; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
        sts.push_back(0); rdys.push_back(1'b1);
        sts.push_back(1); rdys.push_back(1'($urandom));
        case (op)
            6'h23, 6'h2B: begin
                sts.push_back(2); rdys.push_back(1'($urandom));
                for (int i = 0; i < mstall; i++) begin
                    sts.push_back(op == 6'h23 ? 3 : 5); rdys.push_back(1'b0);
                end
                sts.push_back(op == 6'h23 ? 3 : 5); rdys.push_back(1'b1);
                if (op == 6'h23) begin sts.push_back(4); rdys.push_back(1'($urandom)); end
            end
            6'h00: begin
                sts.push_back(6); rdys.push_back(1'($urandom));
                sts.push_back(7); rdys.push_back(1'($urandom));
            end
            6'h04: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
            6'h02: begin sts.push_back(9); rdys.push_back(1'($urandom)); end
            6'h08: begin
                sts.push_back(10); rdys.push_back(1'($urandom));
                sts.push_back(11); rdys.push_back(1'($urandom));
            end
            default: ;
        endcase
        for (int c = 0; c < sts.size(); c++) begin
            opcode    = op;
            mem_ready = rdys[c];
            e.ctl = exp_ctl(sts[c], rdys[c]);
            e.st  = 4'(sts[c]);
            e.ill = (c == 0) ? pend_ill : 1'b0;
            e.cnt = model_cnt;
            exp_q.push_back(e);
            @(posedge clk);
            #2;
        end
        if (is_legal(op)) model_cnt = model_cnt + 1'b1;
        pend_ill = !is_legal(op);
    endtask

    // Monitor: checks one scoreboard entry per cycle, in mid-cycle
    always @(negedge clk) begin
        if (mon_en && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("ctl@%0d", cyc), 32'(act_ctl), 32'(e.ctl));
            checkOutput($sformatf("state@%0d", cyc), 32'(state), 32'(e.st));
            checkOutput($sformatf("illegal@%0d", cyc), 32'(illegal), 32'(e.ill));
            checkOutput($sformatf("count@%0d", cyc), 32'(instr_count), 32'(e.cnt));
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    logic [5:0] legal_ops [6] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};

    initial begin
        logic [5:0] op;
        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;

        // Reset held for 3 cycles: every output must read 0
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 32'(act_ctl), 32'h0);
        checkOutput("reset_state", 32'(state), 32'h0);
        checkOutput("reset_illegal", 32'(illegal), 32'h0);
        checkOutput("reset_count", 32'(instr_count), 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release_MemRead", 32'(MemRead), 32'h1);
        checkOutput("release_IorD", 32'(IorD), 32'h0);

        mon_en = 1'b1;
        // Directed sequence: lw, sw with 3 stall cycles, R/beq/j/addi,
        // then an illegal opcode
        applyStimulus(6'h23, 0, 0);
        applyStimulus(6'h2B, 0, 3);
        applyStimulus(6'h00, 0, 0);
        applyStimulus(6'h04, 0, 0);
        applyStimulus(6'h02, 0, 0);
        applyStimulus(6'h08, 0, 0);
        applyStimulus(6'h3F, 0, 0);
        applyStimulus(6'h08, 1, 0);

        // Random mix: enough retirements to wrap the 4-bit counter repeatedly
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal_ops[$urandom_range(0, 5)];
            end
            applyStimulus(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                          int'($urandom_range(0, 3)));
        end

        // One stalled FETCH cycle exposes the final count and any pending pulse
        opcode    = 6'h00;
        mem_ready = 1'b0;
        exp_q.push_back('{ctl: exp_ctl(0, 1'b0), st: 4'd0, ill: pend_ill, cnt: model_cnt});
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        @(posedge clk);
        #2;

        // Reset asserted in the middle of a stalled store
        opcode    = 6'h2B;
        mem_ready = 1'b1;
        @(posedge clk); #2;
        mem_ready = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        checkOutput("memwr_state", 32'(state), 32'h5);
        checkOutput("memwr_MemWrite", 32'(MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_MemWrite", 32'(MemWrite), 32'h0);
        checkOutput("midrst_ctl", 32'(act_ctl), 32'h0);
        checkOutput("midrst_state", 32'(state), 32'h0);
        checkOutput("midrst_count", 32'(instr_count), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rerelease_state", 32'(state), 32'h0);
        checkOutput("rerelease_ctl", 32'(act_ctl), 32'(exp_ctl(0, 1'b0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
